tubo_scheduler: RTL and testbench
=================================

Name: tubo_scheduler

Overview:
- Sequences the falling-note lane renderer: fetches one 5-lane note row per beat from a pattern ROM, loads its start Y, and issues per-pixel `contar` steps on each frame tick.
- Judges drum-pad presses against a hit window and keeps hit/miss counters.
- Sits between the game top level (start, vsync-derived frame tick, pads) and the lane renderer (`posicionY`, `enable`, `contar`, `maquinaOut`).

Parameters:
- START_Y, 0: Y loaded at the start of each row.
- HIT_Y, 400: centre of the hit zone.
- HIT_WIN, 16: half-width of the hit window; a row is in window when HIT_Y-HIT_WIN <= pos_y <= HIT_Y+HIT_WIN.
- END_Y, 480: Y at which a row ends. Constraint: END_Y <= 1023-STEP.
- STEP, 2: `contar` pulses (pixels) per frame tick; must be >= 1.
- N_NOTES, 16: rows per song.
- ADDR_W, 4: pattern address width; 2^ADDR_W >= N_NOTES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a song
- frame_tick  in  1  one-cycle pulse per video frame
- pads  in  5  drum pad levels, already synchronised to clk
- pat_addr  out  ADDR_W  pattern ROM address
- pat_data  in  5  lane mask for the row; valid one cycle after pat_addr (synchronous ROM)
- lane_mask  out  5  lanes still to be played in the current row
- posicionY  out  10  start Y for the renderer load
- enable  out  1  one-cycle renderer load strobe
- contar  out  1  renderer increment strobe
- maquinaOut  out  1  renderer paint gate
- pos_y  out  10  mirror of the renderer Y
- score  out  8  hit count, saturates at 255
- misses  out  8  miss count, saturates at 255
- hit  out  1  one-cycle pulse per judged hit
- miss  out  1  one-cycle pulse per judged miss
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; all outputs 0, including pat_addr, counters, pos_y and lane_mask.
- States:
  - IDLE -> FETCH on start.
  - FETCH: drive pat_addr; 1 cycle; -> LOAD.
  - LOAD: enable=1, posicionY=START_Y, pos_y<=START_Y, lane_mask<=pat_data, judged<=0; -> FALL.
  - FALL: row animation and judging; -> RESOLVE when pos_y==END_Y and no burst is pending.
  - RESOLVE: if the row index == N_NOTES-1 -> DONE, else pat_addr+1 -> FETCH.
  - DONE -> FETCH on start.
- start handling:
  - From IDLE or DONE, start clears score, misses and pat_addr.
  - start is ignored while busy.
- maquinaOut = 1 in FETCH, LOAD, FALL and RESOLVE.
- Burst (FALL only):
  - frame_tick with burst==0 loads burst=STEP.
  - Each cycle burst>0 and pos_y<END_Y: contar=1, pos_y+1, burst-1.
  - frame_tick while burst>0 is ignored.
  - At END_Y the burst is cleared; no contar is issued beyond END_Y.
- Pad judging:
  - Pads are rising-edge detected per lane (registered previous value).
  - Edge on lane i with lane_mask[i]=1, judged=0 and pos_y in window (registered value, before this cycle's increment): clear lane_mask[i].
  - When lane_mask becomes 0 via pad clears: hit pulse, score+1 (saturating), judged<=1.
  - Edges outside the window, on empty lanes, or after judged=1 are ignored (see optional feature).
- Miss:
  - First cycle with pos_y > HIT_Y+HIT_WIN, judged=0 and lane_mask!=0: miss pulse, misses+1 (saturating), judged<=1.
  - lane_mask keeps its remaining lanes (still painted) until the row ends.
- Simultaneous events:
  - A clearing pad edge in the same cycle as the miss condition: hit wins, no miss.
  - hit and miss are never both high.
- Empty row (pat_data==0): falls normally with judged=1 from LOAD; no hit and no miss.
- Row timing: END_Y-START_Y contar pulses per row, i.e. ceil((END_Y-START_Y)/STEP) frame ticks.

Optional Feature:
- Macro: TUBO_SCHED_PAD_PENALTY_EN.
- When defined, in FALL a pad rising edge that is not a valid clear counts as a penalty:
  - Valid clear: lane_mask[i]=1, in window, judged=0.
  - Penalty: misses+1 (saturating) and a miss pulse; the row is not ended and judged is unchanged.
  - A penalty in the same cycle as the row miss produces one miss pulse and +1 only.
- When undefined, such edges are ignored.

Test Plan:
- Defaults, start, pat_data=5'b00001 for all rows, ticks only, no pads -> per row: enable pulse with posicionY=0, 480 contar pulses over 240 ticks, miss pulse when pos_y=417; after 16 rows done=1, misses=16, score=0, busy=0.
- Row 5'b00101, pad0 edge at pos_y=390, pad2 edge at pos_y=410 -> lane_mask 00101->00100->00000, one hit pulse, score=1, no miss at 417.
- Row 5'b00100, pad2 edge at pos_y=380 only -> ignored, lane_mask stays 00100, miss at pos_y=417, misses=1. With TUBO_SCHED_PAD_PENALTY_EN -> misses=2.
- frame_tick on two consecutive cycles in FALL -> exactly 2 contar pulses, pos_y +2.
- reset=0 mid-FALL at pos_y=200 -> all outputs 0 asynchronously; after release, start -> pat_addr=0, score and misses 0.
- pat_data=0 row -> 480 contar pulses, no hit or miss pulses, counters unchanged; start pulse while busy -> ignored.

Source files
------------

// File: rtl/tubo_scheduler.sv
// Falling-note row sequencer and drum-pad judge for the lane renderer.
// Optional macro TUBO_SCHED_PAD_PENALTY_EN: stray pad edges during FALL count as misses.
module tubo_scheduler #(
  parameter int unsigned START_Y = 0,
  parameter int unsigned HIT_Y   = 400,
  parameter int unsigned HIT_WIN = 16,
  parameter int unsigned END_Y   = 480,
  parameter int unsigned STEP    = 2,
  parameter int unsigned N_NOTES = 16,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              frame_tick,
  input  logic [4:0]        pads,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [4:0]        pat_data,
  output logic [4:0]        lane_mask,
  output logic [9:0]        posicionY,
  output logic              enable,
  output logic              contar,
  output logic              maquinaOut,
  output logic [9:0]        pos_y,
  output logic [7:0]        score,
  output logic [7:0]        misses,
  output logic              hit,
  output logic              miss,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_FALL    = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [9:0]        Y_START   = 10'(START_Y);
  localparam logic [9:0]        Y_LO      = 10'(HIT_Y - HIT_WIN);
  localparam logic [9:0]        Y_HI      = 10'(HIT_Y + HIT_WIN);
  localparam logic [9:0]        Y_END     = 10'(END_Y);
  localparam logic [9:0]        BURST_LD  = 10'(STEP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NOTES - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_mask;
  logic [9:0]        r_pos;
  logic [9:0]        r_burst;
  logic [7:0]        r_score;
  logic [7:0]        r_misses;
  logic              r_judged;
  logic [4:0]        r_pads_q;

  logic       w_fall;
  logic [4:0] w_edge;
  logic       w_in_win;
  logic [4:0] w_clear;
  logic [4:0] w_mask_nx;
  logic       w_hit;
  logic       w_row_miss;
  logic       w_bad;
  logic       w_miss;
  logic       w_contar;

  assign w_fall    = (r_state == S_FALL);
  assign w_edge    = pads & ~r_pads_q;
  assign w_in_win  = (r_pos >= Y_LO) && (r_pos <= Y_HI);
  assign w_clear   = (w_fall && !r_judged && w_in_win) ? (w_edge & r_mask) : 5'b0;
  assign w_mask_nx = r_mask & ~w_clear;
  assign w_hit     = (w_clear != 5'b0) && (w_mask_nx == 5'b0);
  assign w_row_miss = w_fall && !r_judged && (r_pos > Y_HI) && (r_mask != 5'b0) && !w_hit;
  assign w_contar  = w_fall && (r_burst != '0) && (r_pos < Y_END);

`ifdef TUBO_SCHED_PAD_PENALTY_EN
  assign w_bad = w_fall && ((w_edge & ~w_clear) != 5'b0);
`else
  assign w_bad = 1'b0;
`endif

  // A penalty coinciding with a row miss merges into one pulse; a hit suppresses both.
  assign w_miss = (w_row_miss | w_bad) & ~w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_mask   <= '0;
      r_pos    <= '0;
      r_burst  <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_judged <= 1'b0;
      r_pads_q <= '0;
    end else begin
      r_pads_q <= pads;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_FETCH;
            r_addr   <= '0;
            r_score  <= '0;
            r_misses <= '0;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_pos    <= Y_START;
          r_mask   <= pat_data;
          r_judged <= (pat_data == 5'b0);
          r_burst  <= '0;
          r_state  <= S_FALL;
        end
        S_FALL: begin
          r_mask <= w_mask_nx;
          if (w_hit || w_row_miss) r_judged <= 1'b1;
          if (w_hit && (r_score != '1)) r_score <= r_score + 8'd1;
          if (w_miss && (r_misses != '1)) r_misses <= r_misses + 8'd1;
          // Row end drains any partial burst first, then leaves on a clean cycle.
          if (r_pos >= Y_END) begin
            r_burst <= '0;
            if (r_burst == '0) r_state <= S_RESOLVE;
          end else if (r_burst != '0) begin
            r_pos   <= r_pos + 10'd1;
            r_burst <= r_burst - 10'd1;
          end else if (frame_tick) begin
            r_burst <= BURST_LD;
          end
        end
        S_RESOLVE: begin
          if (r_addr == LAST_ADDR) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pat_addr   = r_addr;
  assign lane_mask  = r_mask;
  assign pos_y      = r_pos;
  assign score      = r_score;
  assign misses     = r_misses;
  assign enable     = (r_state == S_LOAD);
  assign posicionY  = enable ? Y_START : '0;
  assign contar     = w_contar;
  assign hit        = w_hit;
  assign miss       = w_miss;
  assign busy       = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                      (r_state == S_FALL)  || (r_state == S_RESOLVE);
  assign maquinaOut = busy;
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_tubo_scheduler.sv
// Self-checking bench for tubo_scheduler: per-row scoreboard plus pad-judging vector table.
module tb_tubo_scheduler;
  localparam int START_Y = 0;
  localparam int HIT_Y   = 400;
  localparam int HIT_WIN = 16;
  localparam int END_Y   = 480;
  localparam int STEP    = 2;
  localparam int N_NOTES = 16;
`ifdef TUBO_SCHED_PAD_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, tick_auto, tick_man, tick_en, frame_tick;
  logic [4:0] pads, pat_data, lane_mask;
  logic [3:0] pat_addr;
  logic [9:0] posicionY, pos_y;
  logic       enable, contar, maquinaOut, hit, miss, busy, done;
  logic [7:0] score, misses;
  logic [4:0] rom [16];

  always #5 clk = ~clk;
  assign frame_tick = tick_auto | tick_man;
  always @(posedge clk) pat_data <= rom[pat_addr];

  tubo_scheduler #(.START_Y(START_Y), .HIT_Y(HIT_Y), .HIT_WIN(HIT_WIN), .END_Y(END_Y),
                   .STEP(STEP), .N_NOTES(N_NOTES), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .pads(pads),
    .pat_addr(pat_addr), .pat_data(pat_data), .lane_mask(lane_mask), .posicionY(posicionY),
    .enable(enable), .contar(contar), .maquinaOut(maquinaOut), .pos_y(pos_y),
    .score(score), .misses(misses), .hit(hit), .miss(miss), .busy(busy), .done(done));

  typedef struct {
    logic [4:0] mask;
    logic [4:0] fmask;
    int         hits;
    int         misses;
    bit         rowmiss;
  } row_t;

  typedef struct {
    logic [4:0] mask;
    int         l0;
    int         y0;
    int         l1;
    int         y1;
    logic [4:0] after1;
    logic [4:0] fmask;
    int         hits;
    int         miss_np;
    int         miss_p;
    bit         rowmiss;
  } vec_t;

  row_t sb[$];
  row_t cur;
  vec_t vt[8];
  int   checks = 0;
  int   errors = 0;
  int   n_contar, n_hit, n_miss, last_y, tot_contar = 0, tcnt = 0;
  bit   row_open = 0, mask_pending = 0, prev_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enable();
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (enable) return;
    end
    chk("wait_enable_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int y);
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (pos_y == 10'(y)) return;
    end
    chk("wait_pos_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      cycle();
      if (done) return;
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  task automatic pad_pulse(input int lane);
    pads[lane] = 1'b1;
    cycle();
    pads = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    tick_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        tcnt++;
        tick_auto = (tcnt % 3 == 0);
      end else begin
        tcnt = 0;
        tick_auto = 1'b0;
      end
    end
  end

  // Row monitor: pops the expected record at each load strobe, judges it at the next row boundary.
  always @(negedge clk) begin
    if (!reset) begin
      row_open = 0;
      mask_pending = 0;
      sb.delete();
    end else begin
      if (mask_pending) begin
        chk("row_loaded_mask", lane_mask, cur.mask);
        mask_pending = 0;
      end
      if (contar) tot_contar++;
      if (hit || miss) chk("hit_miss_exclusive", int'(hit && miss), 0);
      if (row_open) begin
        if (contar) n_contar++;
        if (hit) n_hit++;
        if (miss) begin
          n_miss++;
          last_y = pos_y;
        end
        if (enable || (done && !prev_done)) begin
          chk("row_contar", n_contar, END_Y - START_Y);
          chk("row_hits", n_hit, cur.hits);
          chk("row_misses", n_miss, cur.misses);
          chk("row_final_mask", lane_mask, cur.fmask);
          if (cur.rowmiss) chk("row_miss_y", last_y, HIT_Y + HIT_WIN + 1);
          row_open = 0;
        end
      end
      if (enable) begin
        chk("posicionY", posicionY, START_Y);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          row_open = 1;
          mask_pending = 1;
          n_contar = 0;
          n_hit = 0;
          n_miss = 0;
          last_y = -1;
        end
      end
    end
    prev_done = done;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_score, exp_miss;
    vt[0] = '{5'b00101, 0, 390,  2, 410, 5'b00100, 5'b00000, 1, 0, 0, 1'b0};
    vt[1] = '{5'b00100, 2, 380, -1,   0, 5'b00100, 5'b00100, 0, 1, 2, 1'b1};
    vt[2] = '{5'b00001, 0, 384, -1,   0, 5'b00000, 5'b00000, 1, 0, 0, 1'b0};
    vt[3] = '{5'b00001, 0, 416, -1,   0, 5'b00000, 5'b00000, 1, 0, 0, 1'b0};
    vt[4] = '{5'b00010, 1, 417, -1,   0, 5'b00010, 5'b00010, 0, 1, 1, 1'b1};
    vt[5] = '{5'b00011, 0, 400,  4, 405, 5'b00010, 5'b00010, 0, 1, 2, 1'b1};
    vt[6] = '{5'b00000, 0, 400, -1,   0, 5'b00000, 5'b00000, 0, 0, 1, 1'b0};
    vt[7] = '{5'b00001, 0, 400,  0, 410, 5'b00000, 5'b00000, 1, 0, 1, 1'b0};

    reset = 1'b0; start = 1'b0; pads = '0; tick_man = 1'b0; tick_en = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = 5'b00001;
    repeat (3) cycle();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pat_addr", pat_addr, 0);
    chk("reset_maquinaOut", maquinaOut, 0);
    reset = 1'b1;
    cycle();

    // Song A: every row one lane, no pads -> one miss per row.
    for (int i = 0; i < N_NOTES; i++) sb.push_back('{5'b00001, 5'b00001, 0, 1, 1'b1});
    pulse_start();
    wait_done();
    chk("songA_misses", misses, N_NOTES);
    chk("songA_score", score, 0);
    chk("songA_busy", busy, 0);
    chk("songA_done", done, 1);
    chk("songA_pat_addr", pat_addr, N_NOTES - 1);

    // Song B: vector table in rows 0-7, empty rows after.
    exp_score = 0;
    exp_miss = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        rom[i] = vt[i].mask;
        sb.push_back('{vt[i].mask, vt[i].fmask, vt[i].hits,
                       PEN ? vt[i].miss_p : vt[i].miss_np, vt[i].rowmiss});
        exp_score += vt[i].hits;
        exp_miss += PEN ? vt[i].miss_p : vt[i].miss_np;
      end else begin
        rom[i] = 5'b00000;
        sb.push_back('{5'b00000, 5'b00000, 0, 0, 1'b0});
      end
    end
    pulse_start();
    for (int r = 0; r < 8; r++) begin
      wait_enable();
      wait_pos(vt[r].y0);
      pad_pulse(vt[r].l0);
      chk($sformatf("vec%0d_mask_after_pad", r), lane_mask, vt[r].after1);
      if (vt[r].l1 >= 0) begin
        wait_pos(vt[r].y1);
        pad_pulse(vt[r].l1);
      end
    end

    // Row 8: two back-to-back frame ticks give exactly one burst.
    wait_enable();
    tick_en = 1'b0;
    begin
      int c0;
      repeat (3) cycle();
      chk("burst_pos_before", pos_y, START_Y);
      c0 = tot_contar;
      tick_man = 1'b1;
      cycle();
      cycle();
      tick_man = 1'b0;
      repeat (4) cycle();
      chk("burst_contar_count", tot_contar - c0, STEP);
      chk("burst_pos_after", pos_y, START_Y + STEP);
    end
    tick_en = 1'b1;

    // Row 9: start while busy is ignored.
    wait_enable();
    pulse_start();
    chk("busy_start_pat_addr", pat_addr, 9);
    chk("busy_start_busy", busy, 1);
    wait_done();
    chk("songB_score", score, exp_score);
    chk("songB_misses", misses, exp_miss);
    chk("songB_done", done, 1);
    chk("songB_busy", busy, 0);

    // Song C: asynchronous reset mid-FALL of row 1.
    for (int i = 0; i < 16; i++) begin
      rom[i] = 5'b00001;
      sb.push_back('{5'b00001, 5'b00001, 0, 1, 1'b1});
    end
    pulse_start();
    wait_enable();
    wait_enable();
    wait_pos(200);
    chk("pre_reset_misses", misses, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_pat_addr", pat_addr, 0);
    chk("arst_pos_y", pos_y, 0);
    chk("arst_lane_mask", lane_mask, 0);
    chk("arst_misses", misses, 0);
    chk("arst_score", score, 0);
    chk("arst_maquinaOut", maquinaOut, 0);
    chk("arst_busy", busy, 0);
    chk("arst_strobes", int'({enable, contar, hit, miss, done}), 0);
    chk("arst_posicionY", posicionY, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cycle();
    pulse_start();
    chk("restart_pat_addr", pat_addr, 0);
    chk("restart_score", score, 0);
    chk("restart_misses", misses, 0);
    chk("restart_busy", busy, 1);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
